// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between instruction fetch and load/store, one read in flight.
// Optional fetch starvation guard: define STARVE_GUARD_EN.
//
// state   | meaning
// IDLE    | arbitrate; writes complete here, reads launch from here
// WAIT    | read outstanding, lat_cnt counting down to data capture
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [63:0]       d_wdata_i,
  input  logic [7:0]        d_wmask_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [63:0]       d_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [63:0]       mem_wdata_o,
  output logic [7:0]        mem_wmask_o,
  input  logic [63:0]       mem_rdata_i,
  output logic              busy_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);
  localparam logic       OWN_F    = 1'b0;
  localparam logic       OWN_D    = 1'b1;

  state_e      state_q, state_d;
  logic [2:0]  lat_cnt_q, lat_cnt_d;
  logic        owner_q, owner_d;
  logic        hi_q, hi_d;
  logic        if_rvalid_q, d_rvalid_q;
  logic [31:0] if_rdata_q;
  logic [63:0] d_rdata_q;
  logic        capture;
  logic        fetch_force;

  // Low address bits never reach the doubleword-aligned port.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[1:0], d_addr_i[1:0]};

`ifdef STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_q;

  assign fetch_force = if_req_i && (starve_q >= STARVE_LIM);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= 4'd0;
    end else if (!if_req_i || if_gnt_o) begin
      starve_q <= 4'd0;
    end else if (d_gnt_o && starve_q != 4'hF) begin
      starve_q <= starve_q + 4'd1;
    end
  end
`else
  localparam int unused_starve_max = STARVE_MAX;
  assign fetch_force = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    owner_d     = owner_q;
    hi_d        = hi_q;
    capture     = 1'b0;
    if_gnt_o    = 1'b0;
    d_gnt_o     = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    case (state_q)
      ST_IDLE: begin
        // Grants are combinational, so they must be masked while reset is held.
        if (!rst_i) begin
          if (d_req_i && !fetch_force) begin
            d_gnt_o    = 1'b1;
            mem_en_o   = 1'b1;
            mem_addr_o = {d_addr_i[ADDR_W-1:3], 3'b000};
            if (d_we_i) begin
              mem_we_o    = 1'b1;
              mem_wdata_o = d_wdata_i;
              mem_wmask_o = d_wmask_i;
            end else begin
              owner_d   = OWN_D;
              hi_d      = d_addr_i[2];
              lat_cnt_d = LAT_LOAD;
              state_d   = ST_WAIT;
            end
          end else if (if_req_i) begin
            if_gnt_o   = 1'b1;
            mem_en_o   = 1'b1;
            mem_addr_o = {if_addr_i[ADDR_W-1:3], 3'b000};
            owner_d    = OWN_F;
            hi_d       = if_addr_i[2];
            lat_cnt_d  = LAT_LOAD;
            state_d    = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        lat_cnt_d = lat_cnt_q - 3'd1;
        if (lat_cnt_q <= 3'd1) begin
          lat_cnt_d = 3'd0;
          capture   = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      lat_cnt_q   <= 3'd0;
      owner_q     <= OWN_F;
      hi_q        <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 64'd0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      owner_q     <= owner_d;
      hi_q        <= hi_d;
      if_rvalid_q <= capture && (owner_q == OWN_F);
      d_rvalid_q  <= capture && (owner_q == OWN_D);
      if (capture) begin
        if (owner_q == OWN_D) begin
          d_rdata_q <= mem_rdata_i;
        end else begin
          if_rdata_q <= hi_q ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
        end
      end
    end
  end

  assign if_rvalid_o = if_rvalid_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign busy_o      = (state_q == ST_WAIT);

endmodule
